// File: rtl/xm_pkg.sv
// Shared XMakina definitions: datapath widths, PC increment and fetch FSM state indices.
package xm_pkg;

  localparam int unsigned INSTR_WIDTH = 16;
  localparam int unsigned ADDR_WIDTH  = 16;

  localparam logic [ADDR_WIDTH-1:0] PC_STEP = 16'd2;

  // Enum values are bit positions in the one-hot fetch state vector.
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REQUEST  = 2'd1,
    WAIT_MEM = 2'd2,
    DONE     = 2'd3
  } fetch_states_e;

  localparam int unsigned NUM_FETCH_STATES = 4;

  typedef logic [NUM_FETCH_STATES-1:0] fetch_onehot_t;

  function automatic fetch_onehot_t state_bit(input fetch_states_e s);
    fetch_onehot_t v;
    v    = '0;
    v[s] = 1'b1;
    return v;
  endfunction

  // Sequential next PC; wraps modulo 2^16.
  function automatic logic [ADDR_WIDTH-1:0] next_pc(input logic [ADDR_WIDTH-1:0] addr);
    return addr + PC_STEP;
  endfunction

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Fetch handshake (control unit side) plus instruction memory read port, with decode-side results.
interface instruction_fetch_unit_if;
  import xm_pkg::*;

  logic                   fetch_en;
  logic [ADDR_WIDTH-1:0]  pc;
  logic [INSTR_WIDTH-1:0] mem_rdata;
  logic                   mem_rd_valid;
  logic                   mem_rd;
  logic [ADDR_WIDTH-1:0]  mem_addr;
  logic [INSTR_WIDTH-1:0] instr_reg;
  logic [ADDR_WIDTH-1:0]  pc_next;
  logic                   fetch_done;
  logic                   fetch_fault;
  logic [3:0]             fetch_state_reg;

  modport slave (
    input  fetch_en, pc, mem_rdata, mem_rd_valid,
    output mem_rd, mem_addr, instr_reg, pc_next, fetch_done, fetch_fault, fetch_state_reg
  );

  modport master (
    output fetch_en, pc, mem_rdata, mem_rd_valid,
    input  mem_rd, mem_addr, instr_reg, pc_next, fetch_done, fetch_fault, fetch_state_reg
  );

endinterface

// File: rtl/fetch_timeout_counter.sv
// Counts WAIT_MEM cycles without a memory response; expired flags the last allowed cycle.
module fetch_timeout_counter #(
  parameter int unsigned TIMEOUT_CYCLES = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [7:0] LIMIT = 8'(TIMEOUT_CYCLES - 1);

  logic [7:0] count_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else if (enable) begin
      count_q <= count_q + 8'd1;
    end
  end

  // The increment that happens on this edge is the one that reaches TIMEOUT_CYCLES.
  assign expired = (count_q == LIMIT);

endmodule

// File: rtl/instruction_fetch_unit.sv
// XMakina fetch responder: reads one instruction word at the latched PC and reports done/fault.
module instruction_fetch_unit
  import xm_pkg::*;
#(
  parameter bit                     DEBUG          = 1'b0,
  parameter int unsigned            TIMEOUT_CYCLES = 15,
  parameter logic [INSTR_WIDTH-1:0] FAULT_INSTR    = 16'h0000
) (
  input logic                      clk,
  input logic                      reset,
  instruction_fetch_unit_if.slave  bus
);

  fetch_onehot_t          state_q, state_d;
  logic [ADDR_WIDTH-1:0]  addr_q;
  logic                   mem_rd_q;
  logic [ADDR_WIDTH-1:0]  mem_addr_q;
  logic [INSTR_WIDTH-1:0] instr_q;
  logic [ADDR_WIDTH-1:0]  pc_next_q;
  logic                   done_q;
  logic                   fault_q;

  logic accept, load_data, load_fault, cnt_clr, cnt_en, timeout_expired;

  fetch_timeout_counter #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk     (clk),
    .reset   (reset),
    .clear   (cnt_clr),
    .enable  (cnt_en),
    .expired (timeout_expired)
  );

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d    = state_q;
    accept     = 1'b0;
    load_data  = 1'b0;
    load_fault = 1'b0;
    cnt_clr    = 1'b0;
    cnt_en     = 1'b0;
    unique case (1'b1)
      state_q[IDLE], state_q[DONE]: begin
        if (bus.fetch_en) begin
          accept  = 1'b1;
          state_d = state_bit(REQUEST);
        end
      end
      state_q[REQUEST]: begin
        cnt_clr = 1'b1;
        // A misaligned address spends its one cycle here with no read strobe.
        if (addr_q[0]) begin
          load_fault = 1'b1;
          state_d    = state_bit(DONE);
        end else begin
          state_d = state_bit(WAIT_MEM);
        end
      end
      state_q[WAIT_MEM]: begin
        if (bus.mem_rd_valid) begin
          load_data = 1'b1;
          state_d   = state_bit(DONE);
        end else begin
          cnt_en = 1'b1;
          if (timeout_expired) begin
            load_fault = 1'b1;
            state_d    = state_bit(DONE);
          end
        end
      end
      default: state_d = state_bit(IDLE);
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= state_bit(IDLE);
      addr_q     <= '0;
      mem_rd_q   <= 1'b0;
      mem_addr_q <= '0;
      instr_q    <= '0;
      pc_next_q  <= '0;
      done_q     <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      mem_rd_q <= accept && !bus.pc[0];
      if (accept) begin
        addr_q  <= bus.pc;
        done_q  <= 1'b0;
        fault_q <= 1'b0;
        if (!bus.pc[0]) begin
          mem_addr_q <= {bus.pc[ADDR_WIDTH-1:1], 1'b0};
        end
      end
      if (load_data) begin
        instr_q   <= bus.mem_rdata;
        pc_next_q <= next_pc(addr_q);
        done_q    <= 1'b1;
        fault_q   <= 1'b0;
      end
      if (load_fault) begin
        instr_q   <= FAULT_INSTR;
        pc_next_q <= next_pc(addr_q);
        done_q    <= 1'b1;
        fault_q   <= 1'b1;
      end
    end
  end

  assign bus.mem_rd          = mem_rd_q;
  assign bus.mem_addr        = mem_addr_q;
  assign bus.instr_reg       = instr_q;
  assign bus.pc_next         = pc_next_q;
  assign bus.fetch_done      = done_q;
  assign bus.fetch_fault     = fault_q;
  assign bus.fetch_state_reg = DEBUG ? state_q : 4'b0000;

endmodule
